// File: rtl/bsg_wait_cycles_gate.sv
// bsg_wait_cycles_gate: one-entry valid/ready stage that, after each handoff, holds off
// new input until the downstream settle timer reports ready or the watchdog expires.
module bsg_wait_cycles_gate #(
    parameter int width_p   = 32,
    parameter int timeout_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               activate_o,
    input  logic               wait_ready_i,
    output logic               timeout_o
);
    localparam int cnt_w_lp = (timeout_p + 1 > 1) ? $clog2(timeout_p + 1) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'((timeout_p > 0) ? timeout_p - 1 : 0);
    localparam logic wdog_en_lp = (timeout_p != 0);
    typedef enum logic [1:0] {IDLE, FULL, WAIT} state_e;
    state_e              state_q, state_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic [width_p-1:0]  data_q, data_d;
    logic                wdog_fire;
    // A timer release on the final watchdog cycle wins, so timeout_o is left untouched.
    assign wdog_fire = wdog_en_lp && (cnt_q == cnt_last_lp) && !wait_ready_i;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        data_d    = data_q;
        unique case (state_q)
            IDLE: if (v_i) begin
                state_d = FULL;
                data_d  = data_i;
            end
            FULL: if (yumi_i) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (wait_ready_i || wdog_fire) begin
                state_d   = IDLE;
                timeout_d = timeout_q | wdog_fire;
            end else if (wdog_en_lp) begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            data_q    <= data_d;
        end
    end
    assign ready_o    = (state_q == IDLE);
    assign v_o        = (state_q == FULL);
    assign activate_o = v_o & yumi_i & ~reset_i;
    assign data_o     = data_q;
    assign timeout_o  = timeout_q;
    assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
    assert property (@(posedge clk_i) disable iff (reset_i) activate_o |=> !activate_o);
endmodule

// File: tb/tb_bsg_wait_cycles_gate.sv
// tb_bsg_wait_cycles_gate: two gates (watchdog 64 fed by a settle timer, watchdog 8 fed
// directly) checked every cycle against a phase-level model plus hand-timed scenarios.
module tb_bsg_wait_cycles_gate;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2], v[2], yumi_d[2], yumi[2], tie[2], fmode[2], fval[2], wr[2];
    logic [31:0] din[2];
    logic        rdy[2], vo[2], act[2], to[2];
    logic [31:0] dout[2];
    int          tctr[2], tcyc[2];
    int          checks = 0, errors = 0;
    int          ph[2], waited[2];
    logic        mto[2];
    logic [31:0] mdata[2];

    bsg_wait_cycles_gate #(.width_p(32), .timeout_p(64)) dut0 (
        .clk_i(clk), .reset_i(rst[0]), .v_i(v[0]), .data_i(din[0]), .ready_o(rdy[0]),
        .v_o(vo[0]), .data_o(dout[0]), .yumi_i(yumi[0]), .activate_o(act[0]),
        .wait_ready_i(wr[0]), .timeout_o(to[0]));
    bsg_wait_cycles_gate #(.width_p(32), .timeout_p(8)) dut1 (
        .clk_i(clk), .reset_i(rst[1]), .v_i(v[1]), .data_i(din[1]), .ready_o(rdy[1]),
        .v_o(vo[1]), .data_o(dout[1]), .yumi_i(yumi[1]), .activate_o(act[1]),
        .wait_ready_i(wr[1]), .timeout_o(to[1]));

    function automatic int tmo(input int i);
        return (i == 1) ? 8 : 64;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always_comb
        for (int i = 0; i < 2; i++) begin
            yumi[i] = tie[i] ? vo[i] : yumi_d[i];
            wr[i]   = fmode[i] ? fval[i] : (tctr[i] >= tcyc[i]);
        end

    // Settle timer environment: restarts on activate, ready once it has counted tcyc cycles.
    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (rst[i]) tctr[i] <= tcyc[i];
            else if (act[i]) tctr[i] <= 0;
            else if (tctr[i] < tcyc[i]) tctr[i] <= tctr[i] + 1;

    // Phase model: 0 empty, 1 holding a word, 2 settling (waited = settle cycles elapsed).
    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (rst[i]) begin
                ph[i]  = 0;
                mto[i] = 1'b0;
            end else if (ph[i] == 0) begin
                if (v[i]) begin
                    ph[i]    = 1;
                    mdata[i] = din[i];
                end
            end else if (ph[i] == 1) begin
                if (yumi[i]) begin
                    ph[i]     = 2;
                    waited[i] = 0;
                end
            end else begin
                waited[i]++;
                if (wr[i]) ph[i] = 0;
                else if (waited[i] == tmo(i)) begin
                    ph[i]  = 0;
                    mto[i] = 1'b1;
                end
            end

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m_ready%0d", i), rdy[i], ph[i] == 0);
            chk($sformatf("m_v%0d", i), vo[i], ph[i] == 1);
            chk($sformatf("m_act%0d", i), act[i], yumi[i] && ph[i] == 1 && !rst[i]);
            chk($sformatf("m_timeout%0d", i), to[i], mto[i]);
            if (ph[i] == 1) chk($sformatf("m_data%0d", i), dout[i], mdata[i]);
        end

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_w;
        int sent, got, acts, last, cyc;
        rst = '{1'b1, 1'b1};
        v = '{1'b1, 1'b1};
        yumi_d = '{1'b0, 1'b0};
        tie = '{1'b0, 1'b0};
        fmode = '{1'b0, 1'b1};
        fval = '{1'b0, 1'b0};
        tcyc = '{16, 0};
        din = '{32'h1111_2222, 32'h3333_4444};
        mto = '{1'b0, 1'b0};
        // reset held two cycles with valid asserted
        tick();
        tick();
        rst = '{1'b0, 1'b0};
        v = '{1'b0, 1'b0};
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", rdy[i], 1'b1);
            chk("rst_v", vo[i], 1'b0);
            chk("rst_act", act[i], 1'b0);
            chk("rst_timeout", to[i], 1'b0);
        end
        tick();
        chk("rst_nocapture", vo[0], 1'b0);
        // single transfer through a 16-cycle settle timer
        v[0] = 1'b1;
        din[0] = 32'hDEADBEEF;
        #1 chk("t2_ready_t0", rdy[0], 1'b1);
        tick();
        v[0] = 1'b0;
        #1;
        chk("t2_v", vo[0], 1'b1);
        chk("t2_data", dout[0], 32'hDEADBEEF);
        chk("t2_ready_full", rdy[0], 1'b0);
        yumi_d[0] = 1'b1;
        #1 chk("t2_act_t1", act[0], 1'b1);
        tick();
        yumi_d[0] = 1'b0;
        #1 chk("t2_act_after", act[0], 1'b0);
        for (int k = 1; k <= 17; k++) begin
            chk("t2_busy", rdy[0], 1'b0);
            tick();
            #1;
        end
        chk("t2_ready_t1p18", rdy[0], 1'b1);
        // watchdog fires after exactly 8 settle cycles
        v[1] = 1'b1;
        din[1] = 32'hA5A5_0001;
        tick();
        v[1] = 1'b0;
        yumi_d[1] = 1'b1;
        tick();
        yumi_d[1] = 1'b0;
        #1;
        for (int k = 1; k <= 8; k++) begin
            chk("t3_busy", rdy[1], 1'b0);
            chk("t3_no_timeout_yet", to[1], 1'b0);
            tick();
            #1;
        end
        chk("t3_ready", rdy[1], 1'b1);
        chk("t3_timeout", to[1], 1'b1);
        v[1] = 1'b1;
        din[1] = 32'hA5A5_0002;
        tick();
        v[1] = 1'b0;
        yumi_d[1] = 1'b1;
        tick();
        yumi_d[1] = 1'b0;
        fval[1] = 1'b1;
        tick();
        #1;
        chk("t3_second_ready", rdy[1], 1'b1);
        chk("t3_sticky", to[1], 1'b1);
        // reset while settling clears the sticky timeout
        fval[1] = 1'b0;
        v[1] = 1'b1;
        tick();
        v[1] = 1'b0;
        yumi_d[1] = 1'b1;
        tick();
        yumi_d[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        #1;
        chk("t5w_ready", rdy[1], 1'b1);
        chk("t5w_v", vo[1], 1'b0);
        chk("t5w_timeout", to[1], 1'b0);
        // reset while holding a word discards it
        v[0] = 1'b1;
        din[0] = 32'h1234_5678;
        tick();
        v[0] = 1'b0;
        #1 chk("t5f_full", vo[0], 1'b1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        #1;
        chk("t5f_ready", rdy[0], 1'b1);
        chk("t5f_v", vo[0], 1'b0);
        chk("t5f_timeout", to[0], 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1 chk("t5f_stale", vo[0], 1'b0);
        end
        // timer ready on the final watchdog cycle is a normal release
        v[1] = 1'b1;
        tick();
        v[1] = 1'b0;
        yumi_d[1] = 1'b1;
        tick();
        yumi_d[1] = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        #1 chk("t4_busy_8th", rdy[1], 1'b0);
        fval[1] = 1'b1;
        tick();
        fval[1] = 1'b0;
        #1;
        chk("t4_ready", rdy[1], 1'b1);
        chk("t4_no_timeout", to[1], 1'b0);
        // streaming 100 words with a zero-cycle timer and yumi tied to v_o
        tcyc[0] = 0;
        tie[0] = 1'b1;
        v[0] = 1'b1;
        din[0] = $urandom;
        sent = 0; got = 0; acts = 0; last = -1; cyc = 0;
        while (got < 100 && cyc < 1000) begin
            #1;
            if (act[0]) acts++;
            if (vo[0]) begin
                if (q.size() == 0) chk("t6_spurious", vo[0], 1'b0);
                else begin
                    exp_w = q.pop_front();
                    chk("t6_order", dout[0], exp_w);
                end
                if (last >= 0) chk("t6_gap", cyc - last, 3);
                last = cyc;
                got++;
            end
            if (rdy[0] && v[0]) begin
                q.push_back(din[0]);
                sent++;
                tick();
                din[0] = $urandom;
                v[0] = (sent < 100);
            end else tick();
            cyc++;
        end
        chk("t6_outputs", got, 100);
        chk("t6_activates", acts, 100);
        tie[0] = 1'b0;
        v[0] = 1'b0;
        // randomized traffic, occasional resets, random timer lengths and timer readiness
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                rst[i] = ($urandom_range(0, 99) == 0);
                v[i] = $urandom_range(0, 1);
                din[i] = $urandom;
                yumi_d[i] = (ph[i] == 1) && ($urandom_range(0, 2) != 0);
            end
            if ($urandom_range(0, 49) == 0) tcyc[0] = $urandom_range(0, 80);
            fval[1] = ($urandom_range(0, 11) == 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
